// File: rtl/imem_prefetch_unit_if.sv
// rtl/imem_prefetch_unit_if.sv - core and imem handshake bundle for the prefetch unit
interface imem_prefetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              ip_redirect;
   logic [ADDR_W-1:0] ip_redirect_addr;
   logic              ip_instr_ready;
   logic [DATA_W-1:0] op_instr;
   logic [ADDR_W-1:0] op_instr_addr;
   logic              op_instr_valid;
   logic              op_mem_req_valid;
   logic [ADDR_W-1:0] op_mem_req_addr;
   logic              ip_mem_req_ready;
   logic              ip_mem_rsp_valid;
   logic [DATA_W-1:0] ip_mem_rsp_data;

   // prefetch unit side
   modport master (
      input  ip_redirect, ip_redirect_addr, ip_instr_ready,
             ip_mem_req_ready, ip_mem_rsp_valid, ip_mem_rsp_data,
      output op_instr, op_instr_addr, op_instr_valid,
             op_mem_req_valid, op_mem_req_addr
   );

   // core + imem side
   modport slave (
      output ip_redirect, ip_redirect_addr, ip_instr_ready,
             ip_mem_req_ready, ip_mem_rsp_valid, ip_mem_rsp_data,
      input  op_instr, op_instr_addr, op_instr_valid,
             op_mem_req_valid, op_mem_req_addr
   );
endinterface

// File: rtl/imem_prefetch_unit.sv
// rtl/imem_prefetch_unit.sv - sequential instruction prefetcher with redirect flush
module imem_prefetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter int                PC_STEP  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst,
   imem_prefetch_unit_if.master bus
);
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = PW + 1;
   // stale responses can pile up across back-to-back redirects, so give headroom
   localparam int DROP_W = CW + 3;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_FLUSH = 2'd2} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] fetch_pc, rsp_pc;
   logic [ADDR_W-1:0] fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     fifo_cnt, outstanding;
   logic [DROP_W-1:0] drop_cnt, drop_nxt, drop_sum, drop_redir;
   logic [CW:0]       in_use;
   logic              instr_valid, req_valid, req_fire, push, pop, rsp_drop;

   // handshake qualifiers and credit; redirect suppresses every side effect but the reload
   always_comb begin
      instr_valid = (fifo_cnt != '0);
      in_use      = {1'b0, fifo_cnt} + {1'b0, outstanding};
      req_valid   = (state != S_IDLE) && !bus.ip_redirect && (in_use < DEPTH_C);
      req_fire    = req_valid && bus.ip_mem_req_ready;
      pop         = instr_valid && bus.ip_instr_ready && !bus.ip_redirect;
      rsp_drop    = bus.ip_mem_rsp_valid && (drop_cnt != '0);
      push        = bus.ip_mem_rsp_valid && (drop_cnt == '0) && !bus.ip_redirect;
      drop_sum    = drop_cnt + DROP_W'(outstanding);
      drop_redir  = (bus.ip_mem_rsp_valid && drop_sum != '0) ? drop_sum - DROP_W'(1) : drop_sum;
      if (bus.ip_redirect)
         drop_nxt = drop_redir;
      else if (rsp_drop)
         drop_nxt = drop_cnt - DROP_W'(1);
      else
         drop_nxt = drop_cnt;
   end

   // next-state: flush while stale responses remain in flight
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: if (bus.ip_redirect && drop_nxt != '0) state_nxt = S_FLUSH;
         S_FLUSH: if (drop_nxt == '0) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   // control state, pointers and counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         fifo_cnt    <= '0;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         state    <= state_nxt;
         drop_cnt <= drop_nxt;
         if (bus.ip_redirect) begin
            fetch_pc    <= bus.ip_redirect_addr;
            rsp_pc      <= bus.ip_redirect_addr;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
            if (push) begin
               rsp_pc <= rsp_pc + ADDR_W'(PC_STEP);
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt    <= fifo_cnt + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(push);
         end
      end
   end

   // FIFO payload storage; contents are don't-care while the slot is empty
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= rsp_pc;
         fifo_data[wr_ptr] <= bus.ip_mem_rsp_data;
      end
   end

   assign bus.op_instr_valid   = instr_valid;
   assign bus.op_instr         = instr_valid ? fifo_data[rd_ptr] : '0;
   assign bus.op_instr_addr    = instr_valid ? fifo_addr[rd_ptr] : '0;
   assign bus.op_mem_req_valid = req_valid;
   assign bus.op_mem_req_addr  = fetch_pc;

   // a response with nothing in flight means the imem broke ordering
   rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
      bus.ip_mem_rsp_valid |-> (outstanding != '0 || drop_cnt != '0));
endmodule

// File: tb/tb_imem_prefetch_unit.sv
// tb/tb_imem_prefetch_unit.sv - directed vector bench for imem_prefetch_unit
module tb_imem_prefetch_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   lat = 1;
   int   fire_cnt = 0;
   logic [31:0] q_addr [$];
   int          q_due  [$];

   typedef struct {
      logic        rdy;
      logic        redir;
      logic [31:0] raddr;
      logic        chk_i;
      logic        ival;
      logic [31:0] iaddr;
      logic        rv;
      logic [31:0] maddr;
   } vec_t;
   vec_t tbl [$];

   imem_prefetch_unit_if #(.ADDR_W(32), .DATA_W(32)) mif ();
   imem_prefetch_unit dut (.clk(clk), .rst(rst), .bus(mif));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required summary before it");
      $fatal(1);
   end

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC3A5_5A3C;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (cycle %0d): got %h required %h", name, cyc, act, exp);
      end
   endtask

   // one clock: sample handshakes, advance, update the imem model
   task automatic tick();
      logic        fire, rspv;
      logic [31:0] a;
      #1;
      fire = mif.op_mem_req_valid && mif.ip_mem_req_ready;
      rspv = mif.ip_mem_rsp_valid;
      a    = mif.op_mem_req_addr;
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
         q_addr.delete();
         q_due.delete();
      end else begin
         if (rspv && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (fire) begin
            fire_cnt++;
            q_addr.push_back(a);
            q_due.push_back(cyc - 1 + lat);
         end
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         mif.ip_mem_rsp_valid = 1'b1;
         mif.ip_mem_rsp_data  = mdata(q_addr[0]);
      end else begin
         mif.ip_mem_rsp_valid = 1'b0;
         mif.ip_mem_rsp_data  = '0;
      end
      #1;
   endtask

   task automatic do_reset(input int lat_i, input logic rdy);
      rst = 1'b0;
      mif.ip_redirect = 1'b0;
      mif.ip_instr_ready = rdy;
      lat = lat_i;
      q_addr.delete();
      q_due.delete();
      mif.ip_mem_rsp_valid = 1'b0;
      mif.ip_mem_rsp_data = '0;
      tick();
      tick();
      rst = 1'b1;
      cyc = 0;
      fire_cnt = 0;
      #1;
   endtask

   task automatic add(input logic rdy, input logic redir, input logic [31:0] raddr,
                      input logic chk_i, input logic ival, input logic [31:0] iaddr,
                      input logic rv, input logic [31:0] maddr);
      vec_t v;
      v.rdy = rdy; v.redir = redir; v.raddr = raddr; v.chk_i = chk_i;
      v.ival = ival; v.iaddr = iaddr; v.rv = rv; v.maddr = maddr;
      tbl.push_back(v);
   endtask

   task automatic run_table(input int first, input int last, input bit tick_first);
      for (int i = first; i <= last; i++) begin
         if (i > first || tick_first) tick();
         mif.ip_instr_ready   = tbl[i].rdy;
         mif.ip_redirect      = tbl[i].redir;
         mif.ip_redirect_addr = tbl[i].raddr;
         #1;
         chk("req_valid", 32'(mif.op_mem_req_valid), 32'(tbl[i].rv));
         if (tbl[i].rv) chk("req_addr", mif.op_mem_req_addr, tbl[i].maddr);
         if (tbl[i].chk_i) begin
            chk("instr_valid", 32'(mif.op_instr_valid), 32'(tbl[i].ival));
            if (tbl[i].ival) begin
               chk("instr_addr", mif.op_instr_addr, tbl[i].iaddr);
               chk("instr_data", mif.op_instr, mdata(tbl[i].iaddr));
            end
         end
      end
      mif.ip_redirect = 1'b0;
   endtask

   initial begin
      mif.ip_redirect      = 1'b0;
      mif.ip_redirect_addr = '0;
      mif.ip_instr_ready   = 1'b1;
      mif.ip_mem_req_ready = 1'b1;
      mif.ip_mem_rsp_valid = 1'b0;
      mif.ip_mem_rsp_data  = '0;

      // rows 0..7: streaming out of reset; rows 8..14: redirect near top of address space
      add(1, 0, 0, 1, 0, 0,            0, 0);
      add(1, 0, 0, 1, 0, 0,            1, 32'h0);
      add(1, 0, 0, 1, 0, 0,            1, 32'h4);
      add(1, 0, 0, 1, 1, 32'h0,        1, 32'h8);
      add(1, 0, 0, 1, 1, 32'h4,        1, 32'hC);
      add(1, 0, 0, 1, 1, 32'h8,        1, 32'h10);
      add(1, 0, 0, 1, 1, 32'hC,        1, 32'h14);
      add(1, 0, 0, 1, 1, 32'h10,       1, 32'h18);
      add(1, 1, 32'hFFFF_FFF8, 0, 0, 0, 0, 0);
      add(1, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFF8);
      add(1, 0, 0, 1, 0, 0,            1, 32'hFFFF_FFFC);
      add(1, 0, 0, 1, 1, 32'hFFFF_FFF8, 1, 32'h0);
      add(1, 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'h4);
      add(1, 0, 0, 1, 1, 32'h0,        1, 32'h8);
      add(1, 0, 0, 1, 1, 32'h4,        1, 32'hC);

      // reset values while held in reset
      #3;
      chk("rst_req_valid", 32'(mif.op_mem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(mif.op_instr_valid), 32'd0);
      chk("rst_instr", mif.op_instr, 32'd0);
      chk("rst_instr_addr", mif.op_instr_addr, 32'd0);

      // 1-cycle imem streaming, then wrap-around redirect
      do_reset(1, 1'b1);
      run_table(0, 7, 1'b0);
      run_table(8, 14, 1'b1);

      // core stalled: credit caps requests at DEPTH, head held
      do_reset(1, 1'b0);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (mif.op_instr_valid) chk("stall_head_addr", mif.op_instr_addr, 32'h0);
      end
      chk("stall_req_count", 32'(fire_cnt), 32'd4);
      chk("stall_head_valid", 32'(mif.op_instr_valid), 32'd1);
      mif.ip_instr_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         #1;
         chk("release_valid", 32'(mif.op_instr_valid), 32'd1);
         chk("release_addr", mif.op_instr_addr, 32'(k * 4));
      end

      // 3-cycle imem, redirect with two requests in flight
      do_reset(3, 1'b1);
      tick(); tick(); tick();
      chk("t3_outstanding", 32'(dut.outstanding), 32'd2);
      mif.ip_redirect = 1'b1;
      mif.ip_redirect_addr = 32'h100;
      #1;
      chk("t3_redir_no_req", 32'(mif.op_mem_req_valid), 32'd0);
      tick();
      mif.ip_redirect = 1'b0;
      #1;
      chk("t3_state_flush", 32'(dut.state), 32'd2);
      chk("t3_drop_cnt", 32'(dut.drop_cnt), 32'd2);
      chk("t3_req_addr", mif.op_mem_req_addr, 32'h100);
      chk("t3_req_valid", 32'(mif.op_mem_req_valid), 32'd1);
      for (int k = 5; k <= 7; k++) begin
         tick();
         chk("t3_no_stale", 32'(mif.op_instr_valid), 32'd0);
         if (k == 6) chk("t3_state_fetch", 32'(dut.state), 32'd1);
      end
      tick();
      chk("t3_first_valid", 32'(mif.op_instr_valid), 32'd1);
      chk("t3_first_addr", mif.op_instr_addr, 32'h100);
      chk("t3_first_data", mif.op_instr, mdata(32'h100));

      // redirect coinciding with a response and a pop
      do_reset(3, 1'b1);
      for (int k = 0; k < 5; k++) tick();
      chk("t4_head_valid", 32'(mif.op_instr_valid), 32'd1);
      chk("t4_rsp_present", 32'(mif.ip_mem_rsp_valid), 32'd1);
      chk("t4_outstanding", 32'(dut.outstanding), 32'd3);
      mif.ip_redirect = 1'b1;
      mif.ip_redirect_addr = 32'h200;
      tick();
      mif.ip_redirect = 1'b0;
      #1;
      chk("t4_fifo_empty", 32'(mif.op_instr_valid), 32'd0);
      chk("t4_drop_cnt", 32'(dut.drop_cnt), 32'd2);
      chk("t4_state_flush", 32'(dut.state), 32'd2);
      for (int k = 7; k <= 9; k++) begin
         tick();
         chk("t4_no_stale", 32'(mif.op_instr_valid), 32'd0);
      end
      tick();
      chk("t4_first_addr", mif.op_instr_addr, 32'h200);
      chk("t4_first_data", mif.op_instr, mdata(32'h200));

      // asynchronous reset with FIFO three-quarters full, then restart at RESET_PC
      do_reset(1, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      chk("t6_fifo_cnt", 32'(dut.fifo_cnt), 32'd3);
      rst = 1'b0;
      #1;
      chk("t6_instr_valid", 32'(mif.op_instr_valid), 32'd0);
      chk("t6_instr", mif.op_instr, 32'd0);
      chk("t6_instr_addr", mif.op_instr_addr, 32'd0);
      chk("t6_req_valid", 32'(mif.op_mem_req_valid), 32'd0);
      do_reset(1, 1'b1);
      run_table(0, 7, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
